// File: rtl/thumb_dmem.sv
// Data-memory responder for the pipelined Thumb core: strobe-driven read/write with programmable latencies.
// Optional protocol checker enabled by defining THUMB_DMEM_PROTOCOL_CHECK_EN.
module thumb_dmem #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 read_data_n,
  input  logic                 write_data_n,
  input  logic [WORD_SIZE-1:0] data_address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 rd_ready,
  output logic                 busy,
  output logic                 proto_err
);

  localparam int unsigned CNT_MAX_RW = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_MAX    = (CNT_MAX_RW > HOLD_CYC) ? CNT_MAX_RW : HOLD_CYC;
  localparam int unsigned CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned DEPTH      = 2 ** ADDR_BITS;

  // Counters are loaded with latency-1 so the terminal (cnt==0) edge is the
  // edge the latency lands on; the hold counter follows the same rule.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);
  localparam logic [CNT_W-1:0] HD_LOAD = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_DRIVE,
    S_RD_HOLD,
    S_WR_CAPT,
    S_WR_COMMIT
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [WORD_SIZE-1:0]   r_wbuf;
  logic [WORD_SIZE-1:0]   r_rbuf;
  logic                   r_drive;
  logic                   r_rd_ready;
  logic                   r_busy;
  logic [WORD_SIZE-1:0]   r_mem [DEPTH];

  logic                   w_rd;
  logic                   w_wr;
  logic [ADDR_BITS-1:0]   w_addr;
  logic                   w_mem_we;

  assign w_rd     = ~read_data_n;
  assign w_wr     = ~write_data_n;
  assign w_addr   = data_address[ADDR_BITS-1:0];
  assign w_mem_we = (r_state == S_WR_COMMIT) && (r_cnt == '0);

  generate
    if (ADDR_BITS < WORD_SIZE) begin : g_addr_alias
      logic w_unused_addr;
      assign w_unused_addr = ^data_address[WORD_SIZE-1:ADDR_BITS];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wbuf     <= '0;
      r_rbuf     <= '0;
      r_drive    <= 1'b0;
      r_rd_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            r_state <= S_WR_CAPT;
            r_addr  <= w_addr;
            r_wbuf  <= data;
            r_busy  <= 1'b1;
          end else if (w_rd) begin
            r_state <= S_RD_WAIT;
            r_addr  <= w_addr;
            r_cnt   <= RD_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (!w_rd) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_rbuf     <= r_mem[r_addr];
            r_state    <= S_RD_DRIVE;
            r_drive    <= 1'b1;
            r_rd_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RD_DRIVE: begin
          if (!w_rd) begin
            r_rd_ready <= 1'b0;
            if (HOLD_CYC == 0) begin
              r_state <= S_IDLE;
              r_drive <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_RD_HOLD;
              r_cnt   <= HD_LOAD;
            end
          end else if (w_addr != r_addr) begin
            r_state    <= S_RD_WAIT;
            r_addr     <= w_addr;
            r_cnt      <= RD_LOAD;
            r_drive    <= 1'b0;
            r_rd_ready <= 1'b0;
          end
        end
        S_RD_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_drive <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WR_CAPT: begin
          if (w_wr) begin
            r_addr <= w_addr;
            r_wbuf <= data;
          end else begin
            r_state <= S_WR_COMMIT;
            r_cnt   <= WR_LOAD;
          end
        end
        S_WR_COMMIT: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_drive    <= 1'b0;
          r_rd_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; a write still pending at reset is dropped.
  always_ff @(posedge clk) begin
    if (w_mem_we && reset_n) begin
      r_mem[r_addr] <= r_wbuf;
    end
  end

  assign data     = r_drive ? r_rbuf : {WORD_SIZE{1'bz}};
  assign rd_ready = r_rd_ready;
  assign busy     = r_busy;

`ifdef THUMB_DMEM_PROTOCOL_CHECK_EN
  logic r_proto_err;
  logic w_violation;

  always_comb begin
    w_violation = 1'b0;
    case (r_state)
      S_IDLE:                           w_violation = w_rd && w_wr;
      S_RD_WAIT, S_RD_DRIVE, S_RD_HOLD: w_violation = w_wr;
      S_WR_CAPT:                        w_violation = w_rd || (w_wr && (w_addr != r_addr));
      default:                          w_violation = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_proto_err <= 1'b0;
    end else if (w_violation) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule
